// File: rtl/cntr8_seq_if.sv
// cntr8_seq_if: bundles the command/status signals of the cntr8 sequencer.
//   master modport : requester side (drives start/abort/load_val/inc_cnt,
//                    observes the counter strobes and status)
//   slave modport  : the sequencer itself
// Signals:
//   start, abort        request / cancel a sequence
//   load_val [WIDTH]    preload value captured on the accepting start edge
//   inc_cnt  [CNT_W]    number of increment pulses captured on the same edge
//   o_load, o_d_in      load strobe and data towards the counter
//   o_inc               increment enable towards the counter
//   busy, done, o_state status and debug outputs
interface cntr8_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] load_val;
    logic [CNT_W-1:0] inc_cnt;
    logic             o_load;
    logic [WIDTH-1:0] o_d_in;
    logic             o_inc;
    logic             busy;
    logic             done;
    logic [1:0]       o_state;

    modport master (
        output start, abort, load_val, inc_cnt,
        input  o_load, o_d_in, o_inc, busy, done, o_state
    );

    modport slave (
        input  start, abort, load_val, inc_cnt,
        output o_load, o_d_in, o_inc, busy, done, o_state
    );
endinterface

// File: rtl/cntr8_seq.sv
// cntr8_seq: command sequencer for the cntr8 up-counter. One accepted start
// produces a single load pulse carrying the captured preload value, then the
// captured number of consecutive increment pulses, then a one-cycle done.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset, highest priority
//   bus    cntr8_seq_if slave modport (start/abort/load_val/inc_cnt in,
//          o_load/o_d_in/o_inc/busy/done/o_state out, all registered)
module cntr8_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    cntr8_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_INC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] rem_r;
    logic [CNT_W-1:0] rem_nx_s;
    logic [WIDTH-1:0] d_in_r;
    logic [WIDTH-1:0] d_in_nx_s;

    logic             load_nx_s;
    logic             inc_nx_s;
    logic             busy_nx_s;
    logic             done_nx_s;

    logic             o_load_r;
    logic             o_inc_r;
    logic             busy_r;
    logic             done_r;
    logic [1:0]       o_state_r;

    // State register together with the captured count and preload value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            rem_r   <= {CNT_W{1'b0}};
            d_in_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= next_state_s;
            rem_r   <= rem_nx_s;
            d_in_r  <= d_in_nx_s;
        end
    end

    // Next-state and datapath update; abort overrides every transition but
    // leaves the captured preload value untouched.
    always_comb begin
        next_state_s = state_r;
        rem_nx_s     = rem_r;
        d_in_nx_s    = d_in_r;
        if (bus.abort) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        next_state_s = ST_LOAD;
                        rem_nx_s     = bus.inc_cnt;
                        d_in_nx_s    = bus.load_val;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (rem_r != {CNT_W{1'b0}}) begin
                        next_state_s = ST_INC;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end
                ST_INC: begin
                    // rem counts the increment cycles still owed including
                    // the current one, so rem==1 marks the last INC cycle.
                    rem_nx_s = rem_r - CNT_W'(1);
                    if (rem_r == CNT_W'(1)) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_INC;
                    end
                end
                ST_DONE: begin
                    next_state_s = ST_IDLE;
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Moore output decode of the upcoming state, so the registered outputs
    // line up with the state they describe.
    always_comb begin
        load_nx_s = 1'b0;
        inc_nx_s  = 1'b0;
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
        case (next_state_s)
            ST_IDLE: begin
                load_nx_s = 1'b0;
            end
            ST_LOAD: begin
                load_nx_s = 1'b1;
                busy_nx_s = 1'b1;
            end
            ST_INC: begin
                inc_nx_s  = 1'b1;
                busy_nx_s = 1'b1;
            end
            ST_DONE: begin
                done_nx_s = 1'b1;
            end
            default: begin
                load_nx_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_load_r  <= 1'b0;
            o_inc_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            o_state_r <= 2'd0;
        end else begin
            o_load_r  <= load_nx_s;
            o_inc_r   <= inc_nx_s;
            busy_r    <= busy_nx_s;
            done_r    <= done_nx_s;
            o_state_r <= next_state_s;
        end
    end

    assign bus.o_load  = o_load_r;
    assign bus.o_inc   = o_inc_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.o_state = o_state_r;
    assign bus.o_d_in  = d_in_r;

endmodule

// File: doc/cntr8_seq.md
# cntr8_seq

Command sequencer that drives the control inputs of the 8-bit up-counter `cntr8`. It sits directly upstream of that counter. On a single start request it:

- issues one load pulse carrying a captured preload value,
- then issues a programmed number of consecutive increment pulses,
- then signals completion.

Its outputs connect one-to-one to the counter's `inc`, `load` and `d_in` inputs. It guarantees that `load` and `inc` are never asserted in the same cycle.

## Interface
Parameters:
- `WIDTH`, default 8, width of the preload value and of `o_d_in`. It must match the counter data width.
- `CNT_W`, default 8, width of the increment-count request.

Ports:
- `clk`  input  1  system clock. All state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`. Highest priority.
- `start`  input  1  request to run one sequence. Honoured only in IDLE.
- `abort`  input  1  synchronous cancel. Returns the block to IDLE from any state.
- `load_val`  input  WIDTH  preload value. Captured on the accepted `start` edge.
- `inc_cnt`  input  CNT_W  number of increment pulses to issue. Captured on the accepted `start` edge.
- `o_load`  output  1  load strobe to the counter.
- `o_d_in`  output  WIDTH  preload data to the counter. Valid whenever `o_load`=1.
- `o_inc`  output  1  increment enable to the counter.
- `busy`  output  1  high in the LOAD and INC states.
- `done`  output  1  one-cycle completion pulse.
- `o_state`  output  2  current state encoding, for debug and verification.

## Operation
- State encoding: IDLE=2'd0, LOAD=2'd1, INC=2'd2, DONE=2'd3.
- All outputs are registered Moore outputs, decoded from the state register.
- Reset values: state=IDLE, `o_load`=0, `o_inc`=0, `o_d_in`=0, `busy`=0, `done`=0, `o_state`=0, remaining-count register=0.
- IDLE:
  - If `start`=1 and `abort`=0, capture `load_val` into `o_d_in` and `inc_cnt` into the remaining-count register `rem`, then go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - `o_load`=1, `busy`=1, lasts one cycle.
  - Next state is INC if `rem`≠0, else DONE.
- INC:
  - `o_inc`=1, `busy`=1.
  - `rem` decrements by 1 every cycle.
  - When `rem`==1 at the clock edge, the next state is DONE. This gives exactly `inc_cnt` cycles with `o_inc` high.
- DONE:
  - `done`=1 for one cycle, then go to IDLE.
  - A `start` during DONE is ignored. A new sequence needs `start` sampled in IDLE.
- Priority, highest first: `reset`, then `abort`, then normal transitions.
  - `abort`=1 in any state forces IDLE next cycle, with all strobes deasserted and no `done` pulse.
  - `o_d_in` holds its last captured value after an abort; it is cleared only by `reset`.
- `start` held high continuously:
  - Sequences run back-to-back with one IDLE cycle between DONE and the next LOAD.
  - Each sequence captures fresh `load_val`/`inc_cnt` on its own accepting edge.
- Changes to `load_val`/`inc_cnt` outside the accepting edge have no effect on a running sequence.
- `inc_cnt`=2^CNT_W−1 (255) is legal and yields 255 increment cycles.
- Counter wrap-around is the downstream counter's concern. This block does no arithmetic on `o_d_in`.

## Timing
- Let `start` be accepted at edge k, with N = captured `inc_cnt`. Then:
  - `o_load`=1 during the cycle after edge k.
  - `o_inc`=1 during the cycles after edges k+1 … k+N.
  - `done`=1 during the cycle after edge k+N+1.
  - Back in IDLE after edge k+N+2.
- Total sequence: N+2 cycles of activity. With N=0: LOAD for one cycle, then DONE for one cycle.
- After the sequence, the downstream counter holds (`load_val` + N) mod 2^WIDTH.
- `abort` or `reset` asserted at edge j: all strobes are 0 from the cycle after edge j.
- Mid-operation `reset` behaves identically to power-on reset.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `start`=1 → all outputs 0, `o_state`=0; no `o_load` before reset releases.
- Basic run: `load_val`=8'h2C, `inc_cnt`=5 → one `o_load` cycle with `o_d_in`=8'h2C, then exactly 5 `o_inc` cycles, then one `done` cycle. The attached `cntr8` reads 8'h31.
- Zero count: `inc_cnt`=0, `load_val`=8'hFF → LOAD, DONE, IDLE; `o_inc` never high; counter reads 8'hFF.
- Wrap and max: `load_val`=8'hF0, `inc_cnt`=255 → 255 `o_inc` cycles; counter reads 8'hEF. `o_load` and `o_inc` are never high together; check this every cycle.
- Abort: `abort` pulsed in the 3rd INC cycle of a 10-count run → IDLE next cycle, `o_inc` drops, no `done`. A `start` in the same cycle as `abort` is not accepted.
- Back-to-back and mid-run reset: `start` held high with `inc_cnt`=2 → LOAD, INC, INC, DONE, IDLE, LOAD repeating. `reset` pulsed in INC → outputs 0 on the next cycle.
